// File: rtl/fetch_run_controller.sv
// Run/step/pause sequencer for fetch and pipeline enable; drains the pipeline with NOPs after HALT, then parks.
// Latency: a command sampled at an edge changes state on that edge; outputs are registered-state decodes (Moore).
// Backpressure: none; commands are level-sampled each cycle and ignored in states that do not accept them.
module fetch_run_controller #(
    parameter int                     NB_INSTR     = 32,
    parameter logic [NB_INSTR-1:0]    HALT_INSTR   = {NB_INSTR{1'b1}},
    parameter int                     DRAIN_CYCLES = 4,
    parameter int                     NB_CNT       = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_step,
    input  logic                  i_stop,
    input  logic [NB_INSTR-1:0]   i_ir,
    output logic                  o_valid,
    output logic                  o_nop_fetch,
    output logic                  o_halted,
    output logic                  o_busy,
    output logic [2:0]            o_state,
    output logic [NB_CNT-1:0]     o_cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // Drain length fits a 4-bit counter (legal range 1..15).
    localparam logic [3:0]        DRAIN_LOAD = 4'(DRAIN_CYCLES);
    localparam logic [NB_CNT-1:0] CNT_ONE    = {{(NB_CNT-1){1'b0}}, 1'b1};
    localparam logic [NB_CNT-1:0] CNT_MAX    = {NB_CNT{1'b1}};

    state_t      state;
    state_t      state_next;
    logic [3:0]  drain_cnt;
    logic [3:0]  drain_next;
    logic        clr_cnt;
    logic        halt_hit;

    // Full-width compare; only consulted in RUN and STEP.
    assign halt_hit = (i_ir == HALT_INSTR);

    // State and drain counter registers, synchronous reset overrides everything.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            drain_cnt <= 4'd0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
        end
    end

    // Next-state logic: command priorities and HALT/drain sequencing.
    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        clr_cnt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_RUN;
                    clr_cnt    = 1'b1;
                end else if (i_step) begin
                    state_next = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt_hit) begin
                    state_next = ST_DRAIN;
                    drain_next = DRAIN_LOAD;
                end else if (i_stop) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (halt_hit) begin
                    state_next = ST_DRAIN;
                    drain_next = DRAIN_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Leaving on the count of 1 gives exactly DRAIN_LOAD enabled cycles.
                drain_next = drain_cnt - 4'd1;
                if (drain_cnt <= 4'd1) begin
                    state_next = ST_HALTED;
                    drain_next = 4'd0;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_IDLE;
                drain_next = 4'd0;
            end
        endcase
    end

    // Moore output decode from registered state.
    always_comb begin
        o_valid     = (state == ST_RUN) || (state == ST_STEP) || (state == ST_DRAIN);
        o_nop_fetch = (state == ST_DRAIN);
        o_halted    = (state == ST_HALTED);
        o_busy      = o_valid;
        o_state     = state;
    end

    // Saturating count of enabled cycles; a fresh start from IDLE clears it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_cycle_count <= '0;
        end else if (clr_cnt) begin
            o_cycle_count <= '0;
        end else if (o_valid && (o_cycle_count != CNT_MAX)) begin
            o_cycle_count <= o_cycle_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_fetch_run_controller.sv
// Bench for fetch_run_controller: behavioural model checked every cycle plus directed literal checks.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// A second instance with a 4-bit counter covers saturation.
module tb_fetch_run_controller;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int          DRAIN = 4;

    logic        clk = 1'b0;
    logic        rst, start, step, stop;
    logic [31:0] ir;
    logic        valid, nop, halted, busy;
    logic [2:0]  st;
    logic [31:0] cnt;

    logic        rst2, start2;
    logic        valid2, nop2, halted2, busy2;
    logic [2:0]  st2;
    logic [3:0]  cnt2;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    fetch_run_controller #(.NB_INSTR(32), .HALT_INSTR(32'hFFFF_FFFF), .DRAIN_CYCLES(DRAIN), .NB_CNT(32)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_step(step), .i_stop(stop), .i_ir(ir),
        .o_valid(valid), .o_nop_fetch(nop), .o_halted(halted), .o_busy(busy),
        .o_state(st), .o_cycle_count(cnt)
    );

    fetch_run_controller #(.NB_INSTR(32), .HALT_INSTR(32'hFFFF_FFFF), .DRAIN_CYCLES(DRAIN), .NB_CNT(4)) dut_sat (
        .i_clock(clk), .i_reset(rst2), .i_start(start2), .i_step(1'b0), .i_stop(1'b0), .i_ir(32'h0),
        .o_valid(valid2), .o_nop_fetch(nop2), .o_halted(halted2), .o_busy(busy2),
        .o_state(st2), .o_cycle_count(cnt2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode codes are the externally visible o_state values.
    int          m_mode  = 0;
    int          m_left  = 0;   // enabled cycles still owed to the drain
    longint      m_count = 0;

    function automatic bit m_enabled(input int mode);
        return (mode == 1) || (mode == 2) || (mode == 3);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode  = 0;
            m_left  = 0;
            m_count = 0;
        end else begin
            if (m_enabled(m_mode) && m_count < 64'hFFFF_FFFF) m_count = m_count + 1;
            case (m_mode)
                0: if (start) begin m_mode = 1; m_count = 0; end
                   else if (step) m_mode = 2;
                1: if (ir == HALT) begin m_mode = 3; m_left = DRAIN; end
                   else if (stop) m_mode = 0;
                2: if (ir == HALT) begin m_mode = 3; m_left = DRAIN; end
                   else m_mode = 0;
                3: begin
                       m_left = m_left - 1;
                       if (m_left == 0) m_mode = 4;
                   end
                default: m_mode = m_mode;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_state",  {61'd0, st},  64'(m_mode));
            check("m_valid",  {63'd0, valid}, 64'(m_enabled(m_mode)));
            check("m_nop",    {63'd0, nop},   64'(m_mode == 3));
            check("m_halted", {63'd0, halted}, 64'(m_mode == 4));
            check("m_busy",   {63'd0, busy},  64'(m_enabled(m_mode)));
            check("m_count",  {32'd0, cnt},   m_count);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int  vc;
    logic [5:0] pat;

    initial begin
        rst = 1'b1; start = 0; step = 0; stop = 0; ir = 32'h0000_0013;
        rst2 = 1'b1; start2 = 0;
        tick(); tick();
        rst = 1'b0; rst2 = 1'b0;
        cmp_en = 1'b1;
        check("reset_state", {61'd0, st}, 64'd0);
        check("reset_valid", {63'd0, valid}, 64'd0);
        check("reset_count", {32'd0, cnt}, 64'd0);

        // Start / run 10 cycles / stop.
        start = 1; tick(); start = 0;
        vc = int'(valid);
        repeat (9) begin tick(); vc += int'(valid); end
        stop = 1; tick(); stop = 0;
        vc += int'(valid);
        repeat (3) tick();
        check("run_valid_cycles", 64'(vc), 64'd10);
        check("run_count_hold", {32'd0, cnt}, 64'd10);
        check("run_stop_idle", {61'd0, st}, 64'd0);
        start = 1; tick(); start = 0;
        check("restart_cnt0", {32'd0, cnt}, 64'd0);
        tick();
        check("restart_cnt1", {32'd0, cnt}, 64'd1);
        tick();
        check("restart_cnt2", {32'd0, cnt}, 64'd2);
        stop = 1; tick(); stop = 0;

        // Single-step pulses then held step.
        do_reset();
        vc = 0;
        for (int i = 0; i < 3; i++) begin
            step = 1; tick(); step = 0;
            vc += int'(valid);
            repeat (4) begin tick(); vc += int'(valid); end
        end
        check("step_pulses", 64'(vc), 64'd3);
        check("step_count", {32'd0, cnt}, 64'd3);
        step = 1;
        for (int i = 5; i >= 0; i--) begin tick(); pat[i] = valid; end
        step = 0;
        tick(); tick();
        check("step_hold_pattern", {58'd0, pat}, 64'b101010);

        // HALT on the 7th RUN cycle.
        do_reset();
        start = 1; tick(); start = 0;
        repeat (6) tick();
        ir = HALT; tick(); ir = 32'h0000_0013;
        for (int i = 0; i < DRAIN; i++) begin
            check("drain_valid", {63'd0, valid}, 64'd1);
            check("drain_nop", {63'd0, nop}, 64'd1);
            tick();
        end
        check("halt_halted", {63'd0, halted}, 64'd1);
        check("halt_valid", {63'd0, valid}, 64'd0);
        check("halt_count", {32'd0, cnt}, 64'd11);
        start = 1; step = 1; repeat (3) tick(); start = 0; step = 0;
        check("halted_sticky", {61'd0, st}, 64'd4);
        check("halted_count", {32'd0, cnt}, 64'd11);

        // Reset in the middle of DRAIN.
        do_reset();
        start = 1; tick(); start = 0;
        ir = HALT; tick(); ir = 32'h0000_0013;
        tick();
        check("pre_reset_drain", {61'd0, st}, 64'd3);
        do_reset();
        check("mid_drain_rst_state", {61'd0, st}, 64'd0);
        check("mid_drain_rst_valid", {63'd0, valid}, 64'd0);
        check("mid_drain_rst_nop", {63'd0, nop}, 64'd0);
        check("mid_drain_rst_count", {32'd0, cnt}, 64'd0);

        // Priorities.
        start = 1; step = 1; tick(); start = 0; step = 0;
        check("prio_start_over_step", {61'd0, st}, 64'd1);
        ir = HALT; stop = 1; tick(); ir = 32'h0000_0013; stop = 0;
        check("prio_halt_over_stop", {61'd0, st}, 64'd3);
        repeat (5) tick();
        do_reset();
        step = 1; ir = HALT; tick(); step = 0;
        tick(); ir = 32'h0000_0013;
        check("step_halt_drain", {61'd0, st}, 64'd3);
        repeat (DRAIN) tick();
        check("step_halt_halted", {61'd0, st}, 64'd4);

        // Saturation of a 4-bit counter.
        start2 = 1; tick(); start2 = 0;
        repeat (10) tick();
        check("sat_mid", {60'd0, cnt2}, 64'd10);
        repeat (10) tick();
        check("sat_stick", {60'd0, cnt2}, 64'd15);
        tick();
        check("sat_stick_again", {60'd0, cnt2}, 64'd15);
        check("sat_still_run", {63'd0, valid2}, 64'd1);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
